delay_tuner: RTL and testbench
==============================

# delay_tuner

Clocked supervisor that sets the matched-delay configuration of each stage in the asynchronous controller pipeline. It counts per-stage timing-error detections (`sample`/`Err` events) over a fixed window and steps each stage's delay code up or down. It publishes new codes to the pipeline's delay lines over a 4-phase req/ack handshake. It sits beside the pipeline controllers and is the only writer of their delay codes.

## Interface
- `STAGES`, 3: number of pipeline stages monitored and configured
- `CODE_W`, 4: delay code width per stage; legal codes 0..2^CODE_W-1
- `CODE_INIT`, 8: code loaded into every stage on reset
- `WINDOW`, 16: observation window length in clk cycles (>=2)
- `CNT_W`, 8: per-stage error counter width; counts saturate at 2^CNT_W-1
- `HI_TH`, 4: error count >= HI_TH -> code +1 (slower stage)
- `LO_TH`, 0: error count <= LO_TH -> code -1 (faster stage); requires LO_TH < HI_TH
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  tuning enable, sampled each cycle
- `err`  in  STAGES  per-stage error event, already synchronous to clk; one event per high cycle
- `cfg_ack`  in  1  delay-line acknowledge, asynchronous; synchronized internally by 2 flops
- `cfg_req`  out  1  registered 4-phase request; `code` is stable while high
- `code`  out  STAGES*CODE_W  delay codes, stage s at bits [s*CODE_W +: CODE_W]
- `sat`  out  STAGES  stage code at 2^CODE_W-1
- `busy`  out  1  state != IDLE

## Operation
- Reset values: state IDLE, `code` = CODE_INIT for all stages, counters 0, `cfg_req` 0, `busy` 0, `sat` = (CODE_INIT == max). Reset codes are valid without a handshake.
- **IDLE**: counters held at 0. If `en`=1, go to COUNT and load the window counter with WINDOW-1.
- **COUNT**: each cycle, counter s increments if `err[s]`, saturating. The window counter decrements. The cycle in which it reads 0 is counted, then the state goes to EVAL. If `en`=0, go to IDLE; counters are cleared and codes are kept.
- **EVAL** (1 cycle), applied independently per stage:
  - if cnt >= HI_TH and code < max: code+1
  - else if cnt <= LO_TH and code > 0: code-1
  - Codes are written on the EVAL exit edge and all counters are cleared.
  - If any code changed, go to SETUP. Otherwise go to COUNT (window reloaded) if `en`, else IDLE.
- **SETUP** (1 cycle): go to REQ and set `cfg_req`=1 on the same edge.
- **REQ**: hold `cfg_req`=1 until synced `cfg_ack`=1, then clear `cfg_req` and go to REL.
- **REL**: wait for synced `cfg_ack`=0, then go to COUNT (window reloaded) if `en`, else IDLE.
- `err` is ignored outside COUNT.
- Dropping `en` during SETUP, REQ or REL does not abort. The handshake completes, then the block goes to IDLE.
- `cfg_ack` still high on entry to REQ: wait for it to fall in REL first. This never occurs in legal 4-phase use; the block must not deadlock on it.
- `code` changes only on the EVAL exit edge or on reset. It never changes while `cfg_req`=1 or in REL.
- `rst` asserted in any state forces reset values immediately, without waiting for a clk edge.

## Timing
- Steady-state window period with no change: WINDOW+1 cycles (COUNT x WINDOW, EVAL x 1).
- Code change to `cfg_req` rise: exactly 1 cycle (SETUP).
- `cfg_ack` rise to `cfg_req` fall: 3 edges (2-flop sync plus registered output).
- `cfg_ack` fall to next COUNT: 3 edges.
- `sat` and `busy` are registered-state decodes with no extra latency.

## Structure
- Package `tuner_pkg`:
  - state enum {IDLE, COUNT, EVAL, SETUP, REQ, REL}
  - default parameter constants
- Sub-module `err_window_counter`: one saturating CNT_W counter per stage, with clear and enable inputs and hi/lo compare outputs, instantiated STAGES times in a generate loop.
- The `cfg_ack` synchronizer is inline: two flops, reset to 0.

## Test plan
All scenarios use STAGES=3, CODE_W=4, CODE_INIT=8, WINDOW=16, HI_TH=4, LO_TH=0.
- **Reset**: assert `rst`=0 while in REQ.
  - `cfg_req`=0, `code`={8,8,8}, `busy`=0 before the next clk edge.
- **Mixed step**: in one window, `err[0]` high for 5 cycles, `err[1]` for 1 cycle, `err[2]` never.
  - `code` becomes s0=9, s1=8, s2=7 on the EVAL exit edge.
  - `cfg_req` rises 1 cycle later and stays high until the synced ack.
- **No change**: every stage gets 1..3 errors per window.
  - `cfg_req` never rises.
  - EVAL recurs every 17 cycles.
- **Saturation**:
  - stage 0 at 15 with 10 errors stays at 15, `sat[0]`=1.
  - stage 2 at 0 with 0 errors stays at 0.
  - If no stage changes, there is no handshake.
- **Enable and window edges**:
  - `en` dropped at window cycle 5: IDLE next edge, counters cleared, no `cfg_req`.
  - `en` dropped in REQ: handshake completes, then IDLE.
  - `err` on the final window cycle is counted; `err` in EVAL or SETUP is ignored.
- **Late ack release**: `cfg_ack` held high 10 cycles after `cfg_req` falls.
  - Block stays in REL.
  - COUNT resumes 3 edges after `cfg_ack` falls.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared types and default constants for the delay tuner.
// The state encoding is visible on the top level through a debug port.
package tuner_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        EVAL  = 3'd2,
        SETUP = 3'd3,
        REQ   = 3'd4,
        REL   = 3'd5
    } state_t;

    localparam int STAGES_DEF    = 3;
    localparam int CODE_W_DEF    = 4;
    localparam int CODE_INIT_DEF = 8;
    localparam int WINDOW_DEF    = 16;
    localparam int CNT_W_DEF     = 8;
    localparam int HI_TH_DEF     = 4;
    localparam int LO_TH_DEF     = 0;

endpackage

// File: rtl/err_window_counter.sv
// Saturating per-stage error counter for one observation window.
// Exposes threshold compares so the tuner never reads the raw count.
module err_window_counter #(
    parameter int CNT_W = 8,
    parameter int HI_TH = 4,
    parameter int LO_TH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hi,
    output logic lo
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hi = (cnt >= CNT_W'(HI_TH));
    assign lo = (cnt <= CNT_W'(LO_TH));

endmodule

// File: rtl/delay_tuner.sv
// Windowed error counting per stage, one-step delay code adjustment, and
// 4-phase publication of the new codes to the pipeline delay lines.
module delay_tuner
    import tuner_pkg::*;
#(
    parameter int STAGES    = STAGES_DEF,
    parameter int CODE_W    = CODE_W_DEF,
    parameter int CODE_INIT = CODE_INIT_DEF,
    parameter int WINDOW    = WINDOW_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int HI_TH     = HI_TH_DEF,
    parameter int LO_TH     = LO_TH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [STAGES-1:0]        err,
    input  logic                     cfg_ack,
    output logic                     cfg_req,
    output logic [STAGES*CODE_W-1:0] code,
    output logic [STAGES-1:0]        sat,
    output logic                     busy,
    output state_t                   dbg_state
);

    // Handshake: cfg_req rises only while code is already stable and stays
    // high until the synchronized cfg_ack is seen high; it is then released
    // and the next window starts only after cfg_ack has been seen low again.

    localparam int               WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);
    localparam logic [CODE_W-1:0] CODE_MAX = '1;

    state_t            state, state_nxt;
    logic [WIN_W-1:0]  win_cnt;
    logic              win_load;
    logic              ack_meta, ack_sync;
    logic [CODE_W-1:0] code_q   [STAGES];
    logic [CODE_W-1:0] code_nxt [STAGES];
    logic [STAGES-1:0] hi, lo, changed;
    logic              cnt_clr;

    assign cnt_clr = (state != COUNT) || !en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        err_window_counter #(
            .CNT_W (CNT_W),
            .HI_TH (HI_TH),
            .LO_TH (LO_TH)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .inc ((state == COUNT) && err[s]),
            .hi  (hi[s]),
            .lo  (lo[s])
        );

        assign code[s*CODE_W +: CODE_W] = code_q[s];
        assign sat[s]                   = (code_q[s] == CODE_MAX);
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            code_nxt[s] = code_q[s];
            changed[s]  = 1'b0;
            if (hi[s] && (code_q[s] != CODE_MAX)) begin
                code_nxt[s] = code_q[s] + 1'b1;
                changed[s]  = 1'b1;
            end else if (lo[s] && (code_q[s] != '0)) begin
                code_nxt[s] = code_q[s] - 1'b1;
                changed[s]  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        win_load  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = COUNT;
                    win_load  = 1'b1;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (win_cnt == '0) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (|changed) begin
                    state_nxt = SETUP;
                end else if (en) begin
                    state_nxt = COUNT;
                    win_load  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP: state_nxt = REQ;
            REQ: begin
                if (ack_sync) begin
                    state_nxt = REL;
                end
            end
            REL: begin
                if (!ack_sync) begin
                    state_nxt = en ? COUNT : IDLE;
                    win_load  = en;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            cfg_req  <= 1'b0;
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                code_q[s] <= CODE_W'(CODE_INIT);
            end
        end else begin
            state    <= state_nxt;
            ack_meta <= cfg_ack;
            ack_sync <= ack_meta;
            cfg_req  <= (state_nxt == REQ);
            if (win_load) begin
                win_cnt <= WIN_LOAD;
            end else if ((state == COUNT) && (win_cnt != '0)) begin
                win_cnt <= win_cnt - 1'b1;
            end
            // Codes move only here, so they are frozen across the whole handshake.
            if (state == EVAL) begin
                for (int s = 0; s < STAGES; s++) begin
                    code_q[s] <= code_nxt[s];
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_delay_tuner.sv
// Directed bench for delay_tuner with STAGES=3, CODE_W=4, CODE_INIT=8,
// WINDOW=16, HI_TH=4, LO_TH=0; inputs change and outputs are read on negedge.
module tb_delay_tuner;
    import tuner_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  err = 3'b000;
    logic        cfg_ack = 1'b0;
    logic        cfg_req;
    logic [11:0] code;
    logic [2:0]  sat;
    logic        busy;
    state_t      dbg_state;

    int total = 0;
    int bad = 0;
    int req_cycles = 0;

    delay_tuner dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .err       (err),
        .cfg_ack   (cfg_ack),
        .cfg_req   (cfg_req),
        .code      (code),
        .sat       (sat),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_req === 1'b1) req_cycles++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_state(input state_t s, input int budget, input string name);
        int n = 0;
        while (dbg_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (dbg_state !== s) begin
            bad++;
            $display("FAIL %s: state=%0d required=%0d after %0d cycles", name, dbg_state, s, n);
        end
    endtask

    // Called at the negedge right after COUNT entry; ends at the negedge after
    // the 16th counted edge. Bit i of each mask is the err value for cycle i.
    task automatic drive_window(input logic [15:0] m0, input logic [15:0] m1, input logic [15:0] m2);
        for (int i = 0; i < 16; i++) begin
            err = {m2[i], m1[i], m0[i]};
            @(negedge clk);
        end
        err = 3'b000;
    endtask

    task automatic handshake(input state_t after, input string name);
        cfg_ack = 1'b1;
        wait_state(REL, 10, {name, "_rel"});
        cfg_ack = 1'b0;
        wait_state(after, 10, {name, "_done"});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (code !== 12'h888) begin bad++; $display("FAIL reset_code: got %h required %h", code, 12'h888); end
        total++; if (cfg_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b required 0", cfg_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++; if (sat !== 3'b000) begin bad++; $display("FAIL reset_sat: got %b required 000", sat); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_idle: state=%0d required=%0d", dbg_state, IDLE); end
    endtask

    task automatic test_mixed_step;
        int r0;
        en = 1'b1;
        @(negedge clk);
        total++; if (dbg_state !== COUNT) begin bad++; $display("FAIL mixed_enter: state=%0d required=%0d", dbg_state, COUNT); end
        drive_window(16'h001F, 16'h0080, 16'h0000);
        total++; if (dbg_state !== EVAL) begin bad++; $display("FAIL mixed_eval: state=%0d required=%0d", dbg_state, EVAL); end
        total++; if (code !== 12'h888) begin bad++; $display("FAIL mixed_code_pre: got %h required %h", code, 12'h888); end
        @(negedge clk);
        total++; if (code !== 12'h789) begin bad++; $display("FAIL mixed_code: got %h required %h", code, 12'h789); end
        total++; if (cfg_req !== 1'b0) begin bad++; $display("FAIL mixed_setup_req: got %b required 0", cfg_req); end
        @(negedge clk);
        total++; if (cfg_req !== 1'b1) begin bad++; $display("FAIL mixed_req_rise: got %b required 1", cfg_req); end
        r0 = req_cycles;
        repeat (4) @(negedge clk);
        total++; if (req_cycles - r0 !== 4) begin bad++; $display("FAIL mixed_req_hold: got %0d high cycles required 4", req_cycles - r0); end
        cfg_ack = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (cfg_req !== 1'b1) begin bad++; $display("FAIL mixed_ack_edge2: got %b required 1", cfg_req); end
        @(negedge clk);
        total++; if (cfg_req !== 1'b0) begin bad++; $display("FAIL mixed_ack_edge3: got %b required 0", cfg_req); end
        total++; if (dbg_state !== REL) begin bad++; $display("FAIL mixed_rel: state=%0d required=%0d", dbg_state, REL); end
        cfg_ack = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (dbg_state !== REL) begin bad++; $display("FAIL mixed_rel_edge2: state=%0d required=%0d", dbg_state, REL); end
        @(negedge clk);
        total++; if (dbg_state !== COUNT) begin bad++; $display("FAIL mixed_count_edge3: state=%0d required=%0d", dbg_state, COUNT); end
        total++; if (code !== 12'h789) begin bad++; $display("FAIL mixed_code_hold: got %h required %h", code, 12'h789); end
    endtask

    task automatic test_no_change;
        int r0;
        r0 = req_cycles;
        drive_window(16'h0001, 16'h0011, 16'h0111);
        total++; if (dbg_state !== EVAL) begin bad++; $display("FAIL nochg_eval1: state=%0d required=%0d", dbg_state, EVAL); end
        @(negedge clk);
        total++; if (dbg_state !== COUNT) begin bad++; $display("FAIL nochg_reload: state=%0d required=%0d", dbg_state, COUNT); end
        drive_window(16'h0100, 16'h0401, 16'h8009);
        total++; if (dbg_state !== EVAL) begin bad++; $display("FAIL nochg_period17: state=%0d required=%0d", dbg_state, EVAL); end
        @(negedge clk);
        total++; if (req_cycles !== r0) begin bad++; $display("FAIL nochg_req: got %0d req cycles required %0d", req_cycles, r0); end
        total++; if (code !== 12'h789) begin bad++; $display("FAIL nochg_code: got %h required %h", code, 12'h789); end
    endtask

    task automatic test_window_edges;
        int r0;
        drive_window(16'hF000, 16'h0001, 16'h0002);
        total++; if (dbg_state !== EVAL) begin bad++; $display("FAIL edge_eval: state=%0d required=%0d", dbg_state, EVAL); end
        err = 3'b111;
        @(negedge clk);
        total++; if (code !== 12'h78A) begin bad++; $display("FAIL edge_last_cycle: got %h required %h", code, 12'h78A); end
        @(negedge clk);
        err = 3'b000;
        handshake(COUNT, "edge_hs1");
        drive_window(16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        total++; if (code !== 12'h679) begin bad++; $display("FAIL edge_ignored_err: got %h required %h", code, 12'h679); end
        handshake(COUNT, "edge_hs2");
        err = 3'b111;
        repeat (5) @(negedge clk);
        en = 1'b0;
        err = 3'b000;
        r0 = req_cycles;
        @(negedge clk);
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL edge_en_drop: state=%0d required=%0d", dbg_state, IDLE); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL edge_en_busy: got %b required 0", busy); end
        repeat (3) @(negedge clk);
        total++; if (req_cycles !== r0) begin bad++; $display("FAIL edge_en_req: got %0d required %0d", req_cycles, r0); end
        en = 1'b1;
        @(negedge clk);
        drive_window(16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        total++; if (code !== 12'h568) begin bad++; $display("FAIL edge_cleared: got %h required %h", code, 12'h568); end
        @(negedge clk);
        total++; if (dbg_state !== REQ) begin bad++; $display("FAIL edge_req: state=%0d required=%0d", dbg_state, REQ); end
        en = 1'b0;
        handshake(IDLE, "edge_hs3");
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL edge_req_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_saturation;
        logic [3:0] e0, e1, e2;
        int r0;
        e0 = 4'd8; e1 = 4'd6; e2 = 4'd5;
        en = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 7; w++) begin
            drive_window(16'h03FF, 16'h0001, 16'h0000);
            @(negedge clk);
            if (e0 != 4'd15) e0 = e0 + 4'd1;
            if (e2 != 4'd0) e2 = e2 - 4'd1;
            total++; if (code !== {e2, e1, e0}) begin bad++; $display("FAIL sat_step%0d: got %h required %h", w, code, {e2, e1, e0}); end
            handshake(COUNT, "sat_hs");
        end
        r0 = req_cycles;
        drive_window(16'h03FF, 16'h0001, 16'h0000);
        total++; if (dbg_state !== EVAL) begin bad++; $display("FAIL sat_eval: state=%0d required=%0d", dbg_state, EVAL); end
        @(negedge clk);
        total++; if (dbg_state !== COUNT) begin bad++; $display("FAIL sat_no_setup: state=%0d required=%0d", dbg_state, COUNT); end
        total++; if (code !== 12'h06F) begin bad++; $display("FAIL sat_code: got %h required %h", code, 12'h06F); end
        total++; if (sat !== 3'b001) begin bad++; $display("FAIL sat_flag: got %b required 001", sat); end
        total++; if (req_cycles !== r0) begin bad++; $display("FAIL sat_no_hs: got %0d required %0d", req_cycles, r0); end
    endtask

    task automatic test_late_ack;
        int rel_n;
        drive_window(16'h0000, 16'h0001, 16'hFFFF);
        @(negedge clk);
        total++; if (code !== 12'h16E) begin bad++; $display("FAIL late_code: got %h required %h", code, 12'h16E); end
        total++; if (sat !== 3'b000) begin bad++; $display("FAIL late_sat: got %b required 000", sat); end
        @(negedge clk);
        cfg_ack = 1'b1;
        wait_state(REL, 10, "late_rel");
        rel_n = 0;
        repeat (10) begin
            @(negedge clk);
            if (dbg_state === REL) rel_n++;
        end
        total++; if (rel_n !== 10) begin bad++; $display("FAIL late_hold_rel: got %0d REL cycles required 10", rel_n); end
        cfg_ack = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (dbg_state !== REL) begin bad++; $display("FAIL late_edge2: state=%0d required=%0d", dbg_state, REL); end
        @(negedge clk);
        total++; if (dbg_state !== COUNT) begin bad++; $display("FAIL late_edge3: state=%0d required=%0d", dbg_state, COUNT); end
    endtask

    task automatic test_reset_in_req;
        drive_window(16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        total++; if (code !== 12'h05D) begin bad++; $display("FAIL rreq_code: got %h required %h", code, 12'h05D); end
        @(negedge clk);
        total++; if (cfg_req !== 1'b1) begin bad++; $display("FAIL rreq_req: got %b required 1", cfg_req); end
        #2 rst = 1'b0;
        #1;
        total++; if (cfg_req !== 1'b0) begin bad++; $display("FAIL rreq_async_req: got %b required 0", cfg_req); end
        total++; if (code !== 12'h888) begin bad++; $display("FAIL rreq_async_code: got %h required %h", code, 12'h888); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rreq_async_busy: got %b required 0", busy); end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rreq_idle: state=%0d required=%0d", dbg_state, IDLE); end
    endtask

    initial begin
        test_reset();
        test_mixed_step();
        test_no_change();
        test_window_edges();
        test_saturation();
        test_late_ack();
        test_reset_in_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
